// File: rtl/rte_scan_loader_if.sv
// Byte-stream handshake into the scan loader.
// The image source drives data/valid and the loader returns ready.
interface rte_scan_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/rte_scan_loader.sv
// Scan-chain loader for the enforcement machine.
// Buffers an image streamed in byte 0 first, then shifts it out highest
// address first, LSB first within each byte, while holding the machine in reset.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for load; machine held in reset
// ST_FILL  | accepting image bytes into the buffer
// ST_CLEAR | one-cycle chain clear (scan_reset)
// ST_SHIFT | replaying the buffer onto scan_in/scan_en
// ST_RUN   | image loaded, machine released from reset
module rte_scan_loader #(
  parameter int CONF_LEN  = 14,
  parameter int MEM_LEN   = 64,
  parameter int ADDR_BITS = 7
) (
  input  logic                clk,
  input  logic                reset,
  rte_scan_loader_if.slave    byte_if,
  input  logic                load,
  output logic                scan_in,
  output logic                scan_en,
  output logic                scan_reset,
  output logic                machine_reset,
  output logic                busy,
  output logic                done
);

  localparam int N = CONF_LEN + MEM_LEN;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(N - 1);
  localparam logic [ADDR_BITS-1:0] ONE_ADDR  = ADDR_BITS'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CLEAR,
    ST_SHIFT,
    ST_RUN
  } state_t;

  state_t               state;
  logic [7:0]           img_buf [N];
  logic [ADDR_BITS-1:0] wr_addr;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [2:0]           bit_idx;

  logic [ADDR_BITS-1:0] rd_next;
  logic [2:0]           bit_next;
  logic                 shift_last;
  logic                 accept;

  // Next shift position, so scan_in can be registered one cycle ahead of use.
  always_comb begin
    bit_next   = bit_idx + 3'd1;
    rd_next    = (bit_idx == 3'd7) ? (rd_addr - ONE_ADDR) : rd_addr;
    shift_last = (rd_addr == '0) && (bit_idx == 3'd7);
    accept     = byte_if.in_valid && byte_if.in_ready;
  end

  // Sequencer: state, pointers, buffer writes and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      byte_if.in_ready <= 1'b0;
      scan_in          <= 1'b0;
      scan_en          <= 1'b0;
      scan_reset       <= 1'b0;
      machine_reset    <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      wr_addr          <= '0;
      rd_addr          <= '0;
      bit_idx          <= '0;
      for (int i = 0; i < N; i++) img_buf[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            state            <= ST_FILL;
            wr_addr          <= '0;
            byte_if.in_ready <= 1'b1;
            busy             <= 1'b1;
          end
        end

        ST_FILL: begin
          if (accept) begin
            img_buf[wr_addr] <= byte_if.in_data;
            if (wr_addr == LAST_ADDR) begin
              state            <= ST_CLEAR;
              byte_if.in_ready <= 1'b0;
              scan_reset       <= 1'b1;
            end else begin
              wr_addr <= wr_addr + ONE_ADDR;
            end
          end
        end

        ST_CLEAR: begin
          // First shift cycle presents the LSB of the highest-address byte.
          state      <= ST_SHIFT;
          scan_reset <= 1'b0;
          rd_addr    <= LAST_ADDR;
          bit_idx    <= '0;
          scan_en    <= 1'b1;
          scan_in    <= img_buf[LAST_ADDR][0];
        end

        ST_SHIFT: begin
          if (shift_last) begin
            state         <= ST_RUN;
            scan_en       <= 1'b0;
            scan_in       <= 1'b0;
            machine_reset <= 1'b0;
            done          <= 1'b1;
            busy          <= 1'b0;
          end else begin
            rd_addr <= rd_next;
            bit_idx <= bit_next;
            scan_in <= img_buf[rd_next][bit_next];
          end
        end

        ST_RUN: begin
          if (load) begin
            state            <= ST_FILL;
            wr_addr          <= '0;
            byte_if.in_ready <= 1'b1;
            busy             <= 1'b1;
            machine_reset    <= 1'b1;
            done             <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rte_scan_loader.sv
// Directed bench for rte_scan_loader: reset values, load/shift order,
// backpressure, reset mid-shift and reload from RUN.
module tb_rte_scan_loader;
  localparam int N     = 78;
  localparam int NBITS = 8 * N;

  logic clk = 1'b0;
  logic reset;
  logic load;
  logic scan_in, scan_en, scan_reset, machine_reset, busy, done;

  rte_scan_loader_if byte_if ();

  rte_scan_loader dut (
    .clk           (clk),
    .reset         (reset),
    .byte_if       (byte_if.slave),
    .load          (load),
    .scan_in       (scan_in),
    .scan_en       (scan_en),
    .scan_reset    (scan_reset),
    .machine_reset (machine_reset),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   pos;
    logic exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] img [N];
  logic stream   [NBITS];
  logic stream_a [NBITS];
  int   shift_cnt;
  int   acc_cnt;
  vec_t vecs [16];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string name);
    load = 1'b1;
    tick();
    load = 1'b0;
    check({name, "_in_ready"}, int'(byte_if.in_ready), 1);
    check({name, "_busy"}, int'(busy), 1);
    check({name, "_machine_reset"}, int'(machine_reset), 1);
    check({name, "_done"}, int'(done), 0);
  endtask

  // Streams img[], checks CLEAR, captures the shifted bits into stream[].
  // abort_at > 0 pulses reset after that many shift cycles; load_at > 0
  // pulses load during shift, which must be ignored.
  task automatic feed_and_shift(input bit gaps, input int abort_at, input int load_at);
    int   budget;
    int   bad;
    logic acc;
    logic phase;
    acc_cnt = 0;
    budget  = 0;
    phase   = 1'b1;
    while (acc_cnt < N && budget < 2000) begin
      byte_if.in_data  = img[acc_cnt];
      byte_if.in_valid = gaps ? phase : 1'b1;
      phase            = ~phase;
      acc              = byte_if.in_valid && byte_if.in_ready;
      tick();
      if (acc) acc_cnt++;
      budget++;
    end
    check("bytes_accepted", acc_cnt, N);
    // CLEAR cycle, with an extra byte offered
    byte_if.in_data  = 8'hA5;
    byte_if.in_valid = 1'b1;
    check("clear_scan_reset", int'(scan_reset), 1);
    check("clear_scan_en", int'(scan_en), 0);
    check("clear_in_ready", int'(byte_if.in_ready), 0);
    tick();
    check("extra_byte_refused", int'(byte_if.in_ready), 0);
    byte_if.in_valid = 1'b0;
    shift_cnt = 0;
    bad       = 0;
    budget    = 0;
    while (scan_en && budget < 2000) begin
      if (shift_cnt < NBITS) stream[shift_cnt] = scan_in;
      if (scan_reset || done || !machine_reset || !busy || byte_if.in_ready) bad++;
      shift_cnt++;
      if (shift_cnt == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_scan_en", int'(scan_en), 0);
        check("abort_machine_reset", int'(machine_reset), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_shift_flags", bad, 0);
        return;
      end
      if (shift_cnt == load_at) load = 1'b1;
      tick();
      load = 1'b0;
      budget++;
    end
    check("shift_cycles", shift_cnt, NBITS);
    check("shift_flags", bad, 0);
    check("run_scan_en", int'(scan_en), 0);
    check("run_scan_in", int'(scan_in), 0);
    check("run_done", int'(done), 1);
    check("run_machine_reset", int'(machine_reset), 0);
    check("run_busy", int'(busy), 0);
  endtask

  initial begin
    int mism;
    int ones;

    // Hand-computed bits of the stream for image byte[i] = i.
    vecs[0]  = '{0,   1'b1};  // 0x4D bit0
    vecs[1]  = '{1,   1'b0};
    vecs[2]  = '{2,   1'b1};
    vecs[3]  = '{3,   1'b1};
    vecs[4]  = '{4,   1'b0};
    vecs[5]  = '{5,   1'b0};
    vecs[6]  = '{6,   1'b1};
    vecs[7]  = '{7,   1'b0};
    vecs[8]  = '{8,   1'b0};  // 0x4C bit0
    vecs[9]  = '{10,  1'b1};  // 0x4C bit2
    vecs[10] = '{600, 1'b0};  // 0x02 bit0
    vecs[11] = '{601, 1'b1};  // 0x02 bit1
    vecs[12] = '{608, 1'b1};  // 0x01 bit0
    vecs[13] = '{615, 1'b0};  // 0x01 bit7
    vecs[14] = '{616, 1'b0};  // 0x00 bit0
    vecs[15] = '{623, 1'b0};  // 0x00 bit7

    reset            = 1'b1;
    load             = 1'b0;
    byte_if.in_valid = 1'b0;
    byte_if.in_data  = 8'h00;
    repeat (3) tick();
    check("rst_in_ready", int'(byte_if.in_ready), 0);
    check("rst_scan_in", int'(scan_in), 0);
    check("rst_scan_en", int'(scan_en), 0);
    check("rst_scan_reset", int'(scan_reset), 0);
    check("rst_machine_reset", int'(machine_reset), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;

    // IDLE refuses bytes without load
    byte_if.in_valid = 1'b1;
    repeat (2) tick();
    check("idle_in_ready", int'(byte_if.in_ready), 0);
    check("idle_busy", int'(busy), 0);
    byte_if.in_valid = 1'b0;

    // Full load, back-to-back, counting image
    for (int i = 0; i < N; i++) img[i] = 8'(i);
    do_load("load1");
    feed_and_shift(1'b0, 0, 0);
    for (int k = 0; k < NBITS; k++) stream_a[k] = stream[k];
    foreach (vecs[v]) check($sformatf("bit_%0d", vecs[v].pos), int'(stream_a[vecs[v].pos]), int'(vecs[v].exp));
    mism = 0;
    for (int k = 0; k < NBITS; k++) begin
      logic [7:0] b;
      b = img[N - 1 - k / 8];
      if (stream_a[k] !== b[k % 8]) mism++;
    end
    check("stream_model", mism, 0);
    repeat (3) tick();
    check("run_hold_done", int'(done), 1);

    // Reload from RUN with in_valid gaps and an ignored load mid-shift
    do_load("reload_gaps");
    feed_and_shift(1'b1, 0, 100);
    mism = 0;
    for (int k = 0; k < NBITS; k++) if (stream[k] !== stream_a[k]) mism++;
    check("gaps_stream_same", mism, 0);

    // Reset in the middle of shifting, then a clean full load
    do_load("load_abort");
    feed_and_shift(1'b0, 300, 0);
    repeat (2) tick();
    check("post_abort_idle_ready", int'(byte_if.in_ready), 0);
    check("post_abort_machine_reset", int'(machine_reset), 1);
    do_load("load_after_abort");
    feed_and_shift(1'b0, 0, 0);
    mism = 0;
    for (int k = 0; k < NBITS; k++) if (stream[k] !== stream_a[k]) mism++;
    check("after_abort_stream_same", mism, 0);

    // Reload from RUN with an all-ones image
    for (int i = 0; i < N; i++) img[i] = 8'hFF;
    do_load("reload_ff");
    feed_and_shift(1'b0, 0, 0);
    ones = 0;
    for (int k = 0; k < NBITS; k++) if (stream[k] === 1'b1) ones++;
    check("ff_ones", ones, NBITS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rte_scan_loader.md
# rte_scan_loader

Byte-oriented front end for the enforcement machine's configuration scan chain. Accepts the configuration + program image as a valid/ready byte stream in natural address order (byte 0 first), buffers it, then replays it onto `scan_in`/`scan_en` in the order the chain requires: highest address first, LSB first within each byte. It also owns the machine's `reset` line, holding the machine in reset until the whole image has been shifted in. Sits directly upstream of `top`.

## Interface
- `CONF_LEN`, 14, configuration bytes at the head of the image
- `MEM_LEN`, 64, program memory bytes following the configuration
- `ADDR_BITS`, 7, buffer address width; must satisfy 2^ADDR_BITS >= CONF_LEN+MEM_LEN

- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high block reset
- `in_data`  in  8  image byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts a byte this cycle
- `load`  in  1  single-cycle request to begin a new image load
- `scan_in`  out  1  serial data to `top.scan_in`
- `scan_en`  out  1  shift enable to `top.scan_en`
- `scan_reset`  out  1  chain clear to `top.scan_reset`
- `machine_reset`  out  1  drives `top.reset`
- `busy`  out  1  high in FILL, CLEAR, SHIFT
- `done`  out  1  image loaded; machine running

## Operation
- N = CONF_LEN+MEM_LEN (78 by default). Byte buffer: N x 8 registers or RAM, written at address `wr_addr`.
- States: IDLE, FILL, CLEAR, SHIFT, RUN.
- IDLE: `in_ready`=0, `machine_reset`=1. When `load`=1, go to FILL and set `wr_addr`=0.
- FILL: `in_ready`=1. A byte is accepted when `in_valid`&&`in_ready`. On accept, write `buf[wr_addr]`=`in_data` and increment `wr_addr`. Accepting byte N-1 moves to CLEAR, and `in_ready` drops in the next cycle. `load` is ignored while in FILL.
- CLEAR: lasts exactly one cycle. `scan_reset`=1, `scan_en`=0. Then set byte pointer `rd_addr`=N-1 and bit index `bit_idx`=0, and go to SHIFT.
- SHIFT: each cycle `scan_en`=1 and `scan_in`=`buf[rd_addr][bit_idx]`. Then `bit_idx` increments. On wrap 7->0, `rd_addr` decrements. After the cycle that presents `rd_addr`=0, `bit_idx`=7, go to RUN.
- RUN: `scan_en`=0, `scan_in`=0, `machine_reset`=0, `done`=1. A `load` pulse returns to FILL. In the same cycle `machine_reset` reasserts and `done` clears. The buffer is overwritten; contents are not cleared.
- `scan_in` is 0 whenever `scan_en`=0. It is never X, even for unwritten buffer entries (buffer reset to 0).

## Timing
- Reset values: state IDLE, `in_ready`=0, `scan_in`=0, `scan_en`=0, `scan_reset`=0, `machine_reset`=1, `busy`=0, `done`=0, all pointers 0, buffer 0.
- All outputs are registered.
- `in_ready` is a pure function of state (FILL). There is no combinational path from `in_valid` to `in_ready`.
- `load`: the first accepted byte is possible in the cycle after `load` is sampled.
- Byte N-1 accepted at edge t:
  - `scan_reset` high for the cycle after t.
  - `scan_en` high for the 8N cycles that follow (624 by default).
  - `machine_reset` falls and `done` rises on the edge after the last shift cycle; `scan_en` falls on the same edge.
- `in_valid` gaps in FILL stall only; the byte count is fixed and there is no timeout.
- `load` while in IDLE/RUN takes effect on the next edge. `load` while in CLEAR/SHIFT is ignored.
- `reset` asserted in any state (including mid-SHIFT): the next edge restores all reset values. A partial chain load is abandoned, the machine stays in reset, and a new `load` is required.

## Test plan
- **Reset values:** hold `reset` 3 cycles → all outputs at reset values; `machine_reset`=1; `in_ready`=0.
- **Full load order:** `load`, then bytes `buf[i]`=i for i=0..77 streamed back-to-back → `scan_reset` one cycle; then 624 `scan_en` cycles. First 8 `scan_in` bits are 1,0,1,1,0,0,1,0 (0x4D LSB first). Last 8 bits are 0x00. `done`=1 and `machine_reset`=0 on the following edge.
- **Backpressure gaps:** `in_valid` toggling 1/0 each cycle → exactly 78 bytes accepted; shifted stream identical to back-to-back case. A 79th byte offered after CLEAR is not accepted (`in_ready`=0).
- **End-to-end with `top`:** image with byte 0 = 0x09 → after `done`, `top`'s `db_rd_mem0`=0x09. Both engine states leave FINISH → SETUP on the first cycle after `machine_reset` falls.
- **Reset mid-SHIFT:** `reset` pulse at shift cycle 300 → next edge `scan_en`=0, `machine_reset`=1, `busy`=0. Then `load` plus a full image completes normally.
- **Reload from RUN:** `load` in RUN → `machine_reset`=1 and `done`=0 next edge. A second image (all 0xFF) shifts 624 ones.
